// File: rtl/fx2ft_pkg.sv
// rtl/fx2ft_pkg.sv - shared widths, defaults and special-case constants for fx2ft_arb
package fx2ft_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_ID_W = 2;
    localparam int FX_W     = 24;
    localparam int FT_W     = 32;

    localparam logic [FX_W-1:0] FX_MIN     = 24'h800000;
    localparam logic [FT_W-1:0] FT_ZERO    = 32'h0000_0000;
    localparam logic [FT_W-1:0] FT_NEG_TWO = 32'hC000_0000;

endpackage

// File: rtl/fx2ft_arb_rr_arbiter.sv
// rtl/fx2ft_arb_rr_arbiter.sv - round-robin selector starting the search at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] grant_idx_o
);

    // Walk requesters from ptr upward with wraparound; first active one wins
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fx_to_ft.sv
// rtl/fx_to_ft.sv - combinational Q1.22 signed fixed-point to IEEE-754 single converter
module fx_to_ft
    import fx2ft_pkg::*;
(
    input  logic [FX_W-1:0] fx_i,
    output logic [FT_W-1:0] ft_o
);

    logic [22:0] mag;
    logic [4:0]  lz;
    logic [22:0] frac;

    // Sign-magnitude split, leading-zero count and normalisation; zero and FX_MIN are handled by the caller
    always_comb begin
        mag = fx_i[23] ? (~fx_i[22:0] + 23'd1) : fx_i[22:0];
        lz  = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (mag[i]) lz = 5'(22 - i);
        end
        frac = mag << (lz + 5'd1);
        ft_o = {fx_i[23], 8'd127 - {3'b000, lz}, frac};
    end

endmodule

// File: rtl/fx2ft_arb.sv
// rtl/fx2ft_arb.sv - round-robin sharing of one fixed-to-float converter, two-stage pipeline
module fx2ft_arb
    import fx2ft_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0][FX_W-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    output logic [FT_W-1:0]           out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready
);

    logic            s1_v_q, s1_v_d;
    logic [FX_W-1:0] s1_fx_q, s1_fx_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [FT_W-1:0] s2_ft_q, s2_ft_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            s1_adv, s2_adv;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic [FT_W-1:0] conv_ft;
    logic [FT_W-1:0] ft_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    fx_to_ft u_conv (
        .fx_i (s1_fx_q),
        .ft_o (conv_ft)
    );

    // Handshake, grant gating and next-state of both stages and the round-robin pointer
    always_comb begin
        s2_adv    = !s2_v_q || out_ready;
        s1_adv    = !s1_v_q || s2_adv;
        req_ready = (!reset && s1_adv) ? grant : '0;

        // The converter cannot represent the two endpoints, so force them here
        if (s1_fx_q == '0)         ft_sel = FT_ZERO;
        else if (s1_fx_q == FX_MIN) ft_sel = FT_NEG_TWO;
        else                        ft_sel = conv_ft;

        s1_v_d  = s1_v_q;
        s1_fx_d = s1_fx_q;
        s1_id_d = s1_id_q;
        s2_v_d  = s2_v_q;
        s2_ft_d = s2_ft_q;
        s2_id_d = s2_id_q;
        ptr_d   = ptr_q;

        if (s1_adv) begin
            s1_v_d = |req_ready;
        end
        if (|req_ready) begin
            s1_fx_d = req_data[grant_idx];
            s1_id_d = grant_idx;
            ptr_d   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
        if (s2_adv) begin
            s2_v_d  = s1_v_q;
            s2_ft_d = ft_sel;
            s2_id_d = s1_id_q;
        end
    end

    // Pipeline and pointer registers; reset clears contents so nothing in flight survives
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q  <= 1'b0;
            s1_fx_q <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_ft_q <= '0;
            s2_id_q <= '0;
            ptr_q   <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_fx_q <= s1_fx_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_ft_q <= s2_ft_d;
            s2_id_q <= s2_id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_ft_q;
    assign out_id    = s2_id_q;

endmodule

// File: doc/fx2ft_arb.md
FX2FT_ARB -- requirements
Module: fx2ft_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one fixed-to-float converter.
REQ-002 Parameter ID_W, default 2, width of requester tag, SHALL equal clog2(NREQ).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_data  input  NREQ x 24  per-requester signed Q1.22 fixed-point operand (bit 23 = sign).
REQ-007 req_ready  output  NREQ  one-hot-or-zero grant; transfer when req_valid[i] and req_ready[i] are both high.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_data  output  32  IEEE-754 single-precision result.
REQ-010 out_id  output  ID_W  index of the requester that produced out_data.
REQ-011 out_ready  input  1  consumer accepts result when out_valid and out_ready are both high.

Function
REQ-012 Two register stages: S1 holds {fixed operand, id, valid}; S2 holds {float result, id, valid}; S2 drives out_*.
REQ-013 S2 advances (loads S1 or clears) when S2 empty or out_ready high; S1 advances when S1 empty or S2 advances.
REQ-014 req_ready SHALL be combinational: at most one bit high, only for a requester with req_valid high, and only when S1 advances this cycle.
REQ-015 Latency: operand accepted at edge N appears on out_valid after edge N+1 (visible in cycle N+1) when out_ready is held high; sustained throughput one result per cycle.
REQ-016 Arbitration round-robin: search starts at index ptr; after a grant to i, ptr becomes (i+1) mod NREQ; ptr unchanged when no grant.
REQ-017 Under stall (out_ready low, both stages full), req_ready SHALL be all-zero and S1/S2 contents SHALL hold unchanged.
REQ-018 out_data/out_id SHALL stay stable while out_valid high and out_ready low.
REQ-019 Conversion of S1 operand uses the shared converter, with result sign = bit 23, exponent = 127 minus leading zeros of magnitude, mantissa = magnitude normalised with hidden bit removed.
REQ-020 Special case: operand 0x000000 SHALL produce 0x00000000 (converter output overridden).
REQ-021 Special case: operand 0x800000 (-2.0) SHALL produce 0xC0000000 (converter output overridden).
REQ-022 Requesters not granted SHALL see req_ready low; a requester may drop req_valid without penalty; no request is lost or duplicated.
REQ-023 Result order on out_* SHALL equal grant order.

Reset
REQ-024 While reset high: S1/S2 valid cleared, out_valid = 0, req_ready = all-zero, ptr = 0, out_data = 0, out_id = 0.
REQ-025 Reset asserted mid-operation discards S1/S2 contents; no result for in-flight operands is emitted after reset.
REQ-026 First cycle after reset deasserts, grants are permitted (S1 empty).

Structure
REQ-027 Shared package fx2ft_pkg SHALL hold NREQ/ID_W defaults, fixed width (24), float width (32), and constants FX_MIN = 24'h800000, FT_ZERO = 32'h0, FT_NEG_TWO = 32'hC0000000.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector, ptr; outputs one-hot grant, grant index).
REQ-029 Converter SHALL be the existing fx_to_ft instance, combinational between S1 and S2; no other arithmetic in this block.

Verification
REQ-030 Single requester 0, req_data 0x400000, out_ready high -> out_valid one cycle after accept, out_data 0x3F800000, out_id 0.
REQ-031 Requesters 1 and 3 with 0x200000 and 0xC00000, ptr 0 -> grants 1 then 3; outputs 0x3F000000 id 1, then 0xBF800000 id 3.
REQ-032 All four valid continuously, out_ready high, 8 cycles -> grants 0,1,2,3,0,1,2,3; one result per cycle, ids in same order.
REQ-033 Operands 0x000000 and 0x800000 -> 0x00000000 and 0xC0000000.
REQ-034 out_ready low for 5 cycles with both stages full -> req_ready all-zero, out_data/out_id stable; on release, results drain in order, no loss or duplicate.
REQ-035 Reset asserted with both stages full -> next cycle out_valid 0, ptr 0; no stale result ever appears on out_*.
